access_sequencer: RTL and testbench

//  Sequencing controller for the 4-digit keypad lock. Turns raw enable keys into

---
 rtl/access_sequencer.sv | 107 ++++++++++
 tb/tb_access_sequencer.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/access_sequencer.sv
// Keypad lock sequencer: strobes raw keys, captures one digit per slot, compares the
// full code only once all four are in, counts failures and times OPEN/LOCK windows.
module access_sequencer #(
  parameter logic [15:0] PWD        = 16'h1234,
  parameter int unsigned MAX_FAIL   = 3,
  parameter int unsigned OPEN_TICKS = 12,
  parameter int unsigned LOCK_TICKS = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [3:0]  key,
  input  logic [3:0]  digit,
  output logic        admitted,
  output logic        locked,
  output logic [4:0]  stage,
  output logic [15:0] entered,
  output logic [2:0]  fail_cnt,
  output logic [7:0]  remaining
);

  typedef enum logic [1:0] {ENTRY, CHECK, OPEN, LOCK} state_t;

  localparam logic [7:0] OPEN_LOAD = 8'(OPEN_TICKS);
  localparam logic [7:0] LOCK_LOAD = 8'(LOCK_TICKS);
  localparam logic [2:0] FAIL_MAX  = 3'(MAX_FAIL);

  state_t     state;
  logic [1:0] slot;
  logic [3:0] key_q;
  logic [3:0] strobe;

  always_comb begin
    strobe = key & ~key_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ENTRY;
      slot      <= '0;
      entered   <= '0;
      fail_cnt  <= '0;
      remaining <= '0;
      admitted  <= 1'b0;
      locked    <= 1'b0;
      stage     <= 5'b00001;
      key_q     <= '1;
    end else begin
      key_q <= key;

      // Status flags are decoded from the state register, so they trail it by one edge.
      admitted <= (state == OPEN);
      locked   <= (state == LOCK);
      stage    <= (state == ENTRY) ? {1'b0, 4'b0001 << slot} :
                  (state == OPEN)  ? 5'b10000 : 5'b00000;

      case (state)
        ENTRY: begin
          if (strobe[slot]) begin
            case (slot)
              2'd0:    entered[15:12] <= digit;
              2'd1:    entered[11:8]  <= digit;
              2'd2:    entered[7:4]   <= digit;
              default: entered[3:0]   <= digit;
            endcase
            if (slot == 2'd3) state <= CHECK;
            else              slot  <= slot + 2'd1;
          end
        end

        CHECK: begin
          slot <= '0;
          if (entered == PWD) begin
            state     <= OPEN;
            remaining <= OPEN_LOAD;
            fail_cnt  <= '0;
          end else if ({29'd0, fail_cnt} + 32'd1 < MAX_FAIL) begin
            fail_cnt <= fail_cnt + 3'd1;
            state    <= ENTRY;
            entered  <= '0;
          end else begin
            fail_cnt  <= FAIL_MAX;
            state     <= LOCK;
            remaining <= LOCK_LOAD;
          end
        end

        OPEN, LOCK: begin
          if (tick) begin
            if (remaining == 8'd1) begin
              remaining <= '0;
              state     <= ENTRY;
              slot      <= '0;
              entered   <= '0;
              if (state == LOCK) fail_cnt <= '0;
            end else begin
              remaining <= remaining - 8'd1;
            end
          end
        end

        default: state <= ENTRY;
      endcase
    end
  end

endmodule

// File: tb/tb_access_sequencer.sv
// Bench for access_sequencer: randomized code attempts and timer runs checked against
// an attempt-level model of the lock (expected verdict, failure count, timer values).
module tb_access_sequencer;

  localparam logic [15:0] PWD        = 16'h1234;
  localparam int          MAX_FAIL   = 3;
  localparam int          OPEN_TICKS = 12;
  localparam int          LOCK_TICKS = 30;
  localparam int          M_ENTRY    = 0;
  localparam int          M_OPEN     = 1;
  localparam int          M_LOCK     = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic [3:0]  key;
  logic [3:0]  digit;
  logic        admitted;
  logic        locked;
  logic [4:0]  stage;
  logic [15:0] entered;
  logic [2:0]  fail_cnt;
  logic [7:0]  remaining;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_fail = 0;
  int mode     = M_ENTRY;

  access_sequencer #(
    .PWD(PWD), .MAX_FAIL(MAX_FAIL), .OPEN_TICKS(OPEN_TICKS), .LOCK_TICKS(LOCK_TICKS)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .key(key), .digit(digit),
    .admitted(admitted), .locked(locked), .stage(stage), .entered(entered),
    .fail_cnt(fail_cnt), .remaining(remaining)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; key = '0; tick = 1'b0;
    step();
    rst = 1'b0;
    step();
    exp_fail = 0;
    mode = M_ENTRY;
  endtask

  // One-cycle key pulse followed by three idle cycles; ticks in ENTRY must be ignored.
  task automatic press(input int n, input logic [3:0] d);
    key = 4'(1 << n); digit = d;
    step();
    key = '0;
    for (int i = 0; i < 3; i++) begin
      tick = (mode == M_ENTRY) ? 1'($urandom_range(1)) : 1'b0;
      step();
    end
    tick = 1'b0;
  endtask

  task automatic attempt(input logic [15:0] code, input bit noise);
    logic [15:0] part;
    logic [7:0]  exp_rem;
    bit ok, lk;
    int other;
    part = '0;
    for (int s = 0; s < 3; s++) begin
      if (noise && $urandom_range(1) == 1) begin
        other = (s + 1 + int'($urandom_range(2))) % 4;
        press(other, 4'($urandom));
        n_checks++;
        if ({stage, entered} !== {5'(1 << s), part}) begin
          n_fail++;
          $display("FAIL noise_key slot %0d: got stage=%b entered=%h, expected stage=%b entered=%h",
                   s, stage, entered, 5'(1 << s), part);
        end
      end
      press(s, code[15-4*s -: 4]);
      part[15-4*s -: 4] = code[15-4*s -: 4];
      n_checks++;
      if ({stage, entered} !== {5'(1 << (s + 1)), part}) begin
        n_fail++;
        $display("FAIL capture slot %0d: got stage=%b entered=%h, expected stage=%b entered=%h",
                 s, stage, entered, 5'(1 << (s + 1)), part);
      end
    end

    ok = (code == PWD);
    if (ok) exp_fail = 0;
    else    exp_fail++;
    lk = !ok && (exp_fail == MAX_FAIL);
    exp_rem = ok ? 8'(OPEN_TICKS) : lk ? 8'(LOCK_TICKS) : 8'd0;

    key = 4'b1000; digit = code[3:0];
    step();
    key = '0; tick = 1'($urandom_range(1));
    step();
    tick = 1'b0;
    n_checks++;
    if ({admitted, locked} !== 2'b00) begin
      n_fail++;
      $display("FAIL latency_early: got admitted=%b locked=%b, expected 0 0", admitted, locked);
    end
    step();
    n_checks++;
    if ({admitted, locked, fail_cnt, remaining} !== {ok, lk, 3'(exp_fail), exp_rem}) begin
      n_fail++;
      $display("FAIL verdict code=%h: got adm=%b lock=%b fail=%0d rem=%0d, expected adm=%b lock=%b fail=%0d rem=%0d",
               code, admitted, locked, fail_cnt, remaining, ok, lk, exp_fail, exp_rem);
    end
    n_checks++;
    if (ok && {stage, entered} !== {5'b10000, code}) begin
      n_fail++;
      $display("FAIL open_stage: got stage=%b entered=%h, expected 10000 %h", stage, entered, code);
    end else if (lk && stage !== 5'b00000) begin
      n_fail++;
      $display("FAIL lock_stage: got stage=%b, expected 00000", stage);
    end else if (!ok && !lk && {stage, entered} !== {5'b00001, 16'h0000}) begin
      n_fail++;
      $display("FAIL retry_clear: got stage=%b entered=%h, expected 00001 0000", stage, entered);
    end
    mode = ok ? M_OPEN : lk ? M_LOCK : M_ENTRY;
  endtask

  task automatic run_timer(input bit noise);
    int n;
    bit op;
    op = (mode == M_OPEN);
    n = op ? OPEN_TICKS : LOCK_TICKS;
    for (int i = 1; i <= n; i++) begin
      repeat ($urandom_range(2)) begin
        if (noise) key = 4'($urandom);
        step();
      end
      key = '0;
      tick = 1'b1;
      step();
      tick = 1'b0;
      if (i < n) begin
        n_checks++;
        if ({admitted, locked, remaining} !== {op, !op, 8'(n - i)}) begin
          n_fail++;
          $display("FAIL timer tick %0d: got adm=%b lock=%b rem=%0d, expected adm=%b lock=%b rem=%0d",
                   i, admitted, locked, remaining, op, !op, n - i);
        end
      end
    end
    step();
    exp_fail = 0;
    mode = M_ENTRY;
    n_checks++;
    if ({admitted, locked, stage, entered, fail_cnt, remaining} !==
        {1'b0, 1'b0, 5'b00001, 16'h0000, 3'd0, 8'd0}) begin
      n_fail++;
      $display("FAIL timer_exit: got adm=%b lock=%b stage=%b ent=%h fail=%0d rem=%0d, expected 0 0 00001 0000 0 0",
               admitted, locked, stage, entered, fail_cnt, remaining);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; key = 4'b1111; digit = 4'h3; tick = 1'b0;
    #1 rst = 1'b1;
    #2;
    n_checks++;
    if ({admitted, locked, stage, entered, fail_cnt, remaining} !==
        {1'b0, 1'b0, 5'b00001, 16'h0000, 3'd0, 8'd0}) begin
      n_fail++;
      $display("FAIL reset_values: got adm=%b lock=%b stage=%b ent=%h fail=%0d rem=%0d",
               admitted, locked, stage, entered, fail_cnt, remaining);
    end
    step(); step();
    rst = 1'b0;
    repeat (3) step();
    n_checks++;
    if ({stage, entered} !== {5'b00001, 16'h0000}) begin
      n_fail++;
      $display("FAIL held_through_reset: got stage=%b entered=%h, expected 00001 0000", stage, entered);
    end
    key = '0;
    step();
    press(0, 4'h5);
    n_checks++;
    if ({stage, entered} !== {5'b00010, 16'h5000}) begin
      n_fail++;
      $display("FAIL first_capture: got stage=%b entered=%h, expected 00010 5000", stage, entered);
    end
    do_reset();
  endtask

  task automatic test_correct_entry();
    attempt(PWD, 1'b0);
    run_timer(1'b0);
  endtask

  task automatic test_wrong_lockout();
    for (int i = 0; i < MAX_FAIL; i++) attempt(16'h1235, 1'b0);
    for (int s = 0; s < 4; s++) begin
      press(s, PWD[15-4*s -: 4]);
      n_checks++;
      if ({admitted, locked, stage, remaining} !== {1'b0, 1'b1, 5'b00000, 8'(LOCK_TICKS)}) begin
        n_fail++;
        $display("FAIL locked_keys slot %0d: got adm=%b lock=%b stage=%b rem=%0d, expected 0 1 00000 %0d",
                 s, admitted, locked, stage, remaining, LOCK_TICKS);
      end
    end
    run_timer(1'b0);
    attempt(PWD, 1'b0);
    run_timer(1'b1);
  endtask

  task automatic test_key_discipline();
    do_reset();
    press(2, 4'h6);
    n_checks++;
    if ({stage, entered} !== {5'b00001, 16'h0000}) begin
      n_fail++;
      $display("FAIL wrong_slot_key: got stage=%b entered=%h, expected 00001 0000", stage, entered);
    end
    key = 4'b0001; digit = 4'h7;
    step();
    digit = 4'h8;
    repeat (9) step();
    key = '0;
    step();
    n_checks++;
    if ({stage, entered} !== {5'b00010, 16'h7000}) begin
      n_fail++;
      $display("FAIL held_key: got stage=%b entered=%h, expected 00010 7000", stage, entered);
    end
    do_reset();
    key = 4'b0011; digit = 4'h9;
    step();
    key = '0;
    step(); step();
    n_checks++;
    if ({stage, entered} !== {5'b00010, 16'h9000}) begin
      n_fail++;
      $display("FAIL simultaneous_keys: got stage=%b entered=%h, expected 00010 9000", stage, entered);
    end
    do_reset();
  endtask

  task automatic test_two_fails_then_ok();
    attempt(16'h4321, 1'b1);
    attempt(16'h1235, 1'b1);
    attempt(PWD, 1'b1);
    run_timer(1'b1);
  endtask

  task automatic test_random();
    logic [15:0] code;
    for (int r = 0; r < 8; r++) begin
      code = ($urandom_range(2) == 0) ? PWD : 16'($urandom);
      attempt(code, 1'b1);
      if (mode != M_ENTRY) run_timer(1'b1);
    end
  endtask

  task automatic test_reset_mid();
    attempt(PWD, 1'b0);
    tick = 1'b1; step(); tick = 1'b0; step();
    key = 4'b0001;
    step();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({admitted, locked, stage, entered, fail_cnt, remaining} !==
        {1'b0, 1'b0, 5'b00001, 16'h0000, 3'd0, 8'd0}) begin
      n_fail++;
      $display("FAIL reset_mid: got adm=%b lock=%b stage=%b ent=%h fail=%0d rem=%0d",
               admitted, locked, stage, entered, fail_cnt, remaining);
    end
    exp_fail = 0;
    mode = M_ENTRY;
    step();
    rst = 1'b0;
    repeat (3) step();
    n_checks++;
    if ({stage, entered} !== {5'b00001, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_mid_held: got stage=%b entered=%h, expected 00001 0000", stage, entered);
    end
    key = '0;
    step();
    press(0, 4'h5);
    n_checks++;
    if ({stage, entered} !== {5'b00010, 16'h5000}) begin
      n_fail++;
      $display("FAIL reset_mid_repress: got stage=%b entered=%h, expected 00010 5000", stage, entered);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_correct_entry();
    test_wrong_lockout();
    test_key_discipline();
    test_two_fails_then_ok();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
